// File: rtl/segre_mem_arbiter.sv
// Arbitrates the single main-memory port between the instruction and data caches.
// IC wins ties unless it has won MAX_IC_STREAK times in a row while DC was waiting.
module segre_mem_arbiter #(
  parameter int unsigned ADDR_SIZE     = 32,
  parameter int unsigned LINE_SIZE     = 128,
  parameter int unsigned MAX_IC_STREAK = 4
) (
  input  logic                 clk_i,
  input  logic                 rsn_i,
  // IC requester
  input  logic                 ic_req_i,
  input  logic [ADDR_SIZE-1:0] ic_addr_i,
  output logic                 ic_gnt_o,
  output logic                 ic_rvalid_o,
  output logic [LINE_SIZE-1:0] ic_rdata_o,
  // DC requester
  input  logic                 dc_req_i,
  input  logic                 dc_we_i,
  input  logic [ADDR_SIZE-1:0] dc_addr_i,
  input  logic [LINE_SIZE-1:0] dc_wdata_i,
  output logic                 dc_gnt_o,
  output logic                 dc_rvalid_o,
  output logic [LINE_SIZE-1:0] dc_rdata_o,
  // Memory side
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [ADDR_SIZE-1:0] mem_addr_o,
  output logic [LINE_SIZE-1:0] mem_wdata_o,
  input  logic                 mem_rvalid_i,
  input  logic [LINE_SIZE-1:0] mem_rdata_i,
  // Status
  output logic                 sel_mem_req_o,
  output logic                 busy_o
);

  localparam int unsigned STREAK_W = $clog2(MAX_IC_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_IC_STREAK);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IC = 2'd1,
    WAIT_DC = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [STREAK_W-1:0]    ic_streak_q, ic_streak_d;
  logic                   mem_req_q, mem_req_d;
  logic                   ic_gnt_q, ic_gnt_d;
  logic                   dc_gnt_q, dc_gnt_d;
  logic                   mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0]   mem_addr_q, mem_addr_d;
  logic [LINE_SIZE-1:0]   mem_wdata_q, mem_wdata_d;
  logic [STREAK_W-1:0]    streak_inc;

  assign streak_inc = (ic_streak_q == STREAK_MAX) ? STREAK_MAX
                                                  : ic_streak_q + STREAK_W'(1);

  // State and transaction registers
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q     <= IDLE;
      ic_streak_q <= '0;
      mem_req_q   <= 1'b0;
      ic_gnt_q    <= 1'b0;
      dc_gnt_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ic_streak_q <= ic_streak_d;
      mem_req_q   <= mem_req_d;
      ic_gnt_q    <= ic_gnt_d;
      dc_gnt_q    <= dc_gnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // Arbitration, transaction capture and completion
  always_comb begin
    state_d     = state_q;
    ic_streak_d = ic_streak_q;
    mem_req_d   = 1'b0;
    ic_gnt_d    = 1'b0;
    dc_gnt_d    = 1'b0;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;

    unique case (state_q)
      IDLE: begin
        if (ic_req_i && !(dc_req_i && (ic_streak_q == STREAK_MAX))) begin
          state_d     = WAIT_IC;
          mem_req_d   = 1'b1;
          ic_gnt_d    = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = ic_addr_i;
          mem_wdata_d = '0;
          ic_streak_d = dc_req_i ? streak_inc : '0;
        end else if (dc_req_i) begin
          state_d     = WAIT_DC;
          mem_req_d   = 1'b1;
          dc_gnt_d    = 1'b1;
          mem_we_d    = dc_we_i;
          mem_addr_d  = dc_addr_i;
          mem_wdata_d = dc_wdata_i;
          ic_streak_d = '0;
        end else begin
          ic_streak_d = '0;
        end
      end
      WAIT_IC, WAIT_DC: begin
        if (mem_rvalid_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_req_o     = mem_req_q;
  assign ic_gnt_o      = ic_gnt_q;
  assign dc_gnt_o      = dc_gnt_q;
  assign mem_we_o      = mem_we_q;
  assign mem_addr_o    = mem_addr_q;
  assign mem_wdata_o   = mem_wdata_q;
  assign sel_mem_req_o = (state_q == WAIT_DC);
  assign busy_o        = (state_q != IDLE);

  // Response routing is same-cycle so the owner sees data with the memory pulse
  assign ic_rvalid_o = (state_q == WAIT_IC) && mem_rvalid_i;
  assign dc_rvalid_o = (state_q == WAIT_DC) && mem_rvalid_i;
  assign ic_rdata_o  = mem_rdata_i;
  assign dc_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Directed bench for segre_mem_arbiter: one task per scenario, inline checks.
module tb_segre_mem_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 128;

  logic          clk_i, rsn_i;
  logic          ic_req_i, ic_gnt_o, ic_rvalid_o;
  logic [AW-1:0] ic_addr_i;
  logic [LW-1:0] ic_rdata_o;
  logic          dc_req_i, dc_we_i, dc_gnt_o, dc_rvalid_o;
  logic [AW-1:0] dc_addr_i;
  logic [LW-1:0] dc_wdata_i, dc_rdata_o;
  logic          mem_req_o, mem_we_o, mem_rvalid_i;
  logic [AW-1:0] mem_addr_o;
  logic [LW-1:0] mem_wdata_o, mem_rdata_i;
  logic          sel_mem_req_o, busy_o;

  int n_cmp = 0;
  int n_err = 0;

  segre_mem_arbiter #(.ADDR_SIZE(AW), .LINE_SIZE(LW), .MAX_IC_STREAK(4)) dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .ic_req_i(ic_req_i), .ic_addr_i(ic_addr_i), .ic_gnt_o(ic_gnt_o),
    .ic_rvalid_o(ic_rvalid_o), .ic_rdata_o(ic_rdata_o),
    .dc_req_i(dc_req_i), .dc_we_i(dc_we_i), .dc_addr_i(dc_addr_i),
    .dc_wdata_i(dc_wdata_i), .dc_gnt_o(dc_gnt_o), .dc_rvalid_o(dc_rvalid_o),
    .dc_rdata_o(dc_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .sel_mem_req_o(sel_mem_req_o), .busy_o(busy_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rsn_i = 1'b0;
    ic_req_i = 0; ic_addr_i = '0;
    dc_req_i = 0; dc_we_i = 0; dc_addr_i = '0; dc_wdata_i = '0;
    mem_rvalid_i = 0; mem_rdata_i = '0;
    #12;
    n_cmp++;
    if ({ic_gnt_o, ic_rvalid_o, dc_gnt_o, dc_rvalid_o, mem_req_o, mem_we_o,
         sel_mem_req_o, busy_o} !== 8'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b expected 00000000",
               {ic_gnt_o, ic_rvalid_o, dc_gnt_o, dc_rvalid_o, mem_req_o, mem_we_o,
                sel_mem_req_o, busy_o});
    end
    n_cmp++;
    if (mem_addr_o !== '0 || mem_wdata_o !== '0) begin
      n_err++;
      $display("FAIL reset_data: addr %h wdata %h expected zero", mem_addr_o, mem_wdata_o);
    end
    @(negedge clk_i);
    rsn_i = 1'b1;
  endtask

  task automatic test_ic_only();
    logic [LW-1:0] d;
    d = {4{32'hC0DE_0001}};
    tick();                              // cycle 0
    ic_req_i = 1; ic_addr_i = 32'h1000_0040;
    @(negedge clk_i);
    n_cmp++;
    if ({mem_req_o, busy_o} !== 2'b00) begin
      n_err++; $display("FAIL ic_c0: req/busy %b expected 00", {mem_req_o, busy_o});
    end
    tick();                              // cycle 1
    @(negedge clk_i);
    n_cmp++;
    if ({mem_req_o, ic_gnt_o, dc_gnt_o, sel_mem_req_o, busy_o, mem_we_o} !== 6'b110010) begin
      n_err++;
      $display("FAIL ic_c1: req,igt,dgt,sel,busy,we %b expected 110010",
               {mem_req_o, ic_gnt_o, dc_gnt_o, sel_mem_req_o, busy_o, mem_we_o});
    end
    n_cmp++;
    if (mem_addr_o !== 32'h1000_0040 || mem_wdata_o !== '0) begin
      n_err++; $display("FAIL ic_c1_addr: addr %h wdata %h expected 10000040/0", mem_addr_o, mem_wdata_o);
    end
    tick();                              // cycle 2
    @(negedge clk_i);
    n_cmp++;
    if ({mem_req_o, ic_gnt_o, busy_o} !== 3'b001) begin
      n_err++; $display("FAIL ic_c2: req,gnt,busy %b expected 001", {mem_req_o, ic_gnt_o, busy_o});
    end
    tick();                              // cycle 3
    tick();                              // cycle 4
    mem_rvalid_i = 1; mem_rdata_i = d;
    @(negedge clk_i);
    n_cmp++;
    if ({ic_rvalid_o, dc_rvalid_o} !== 2'b10 || ic_rdata_o !== d) begin
      n_err++;
      $display("FAIL ic_c4_resp: rvalid %b rdata %h expected 10 / %h", {ic_rvalid_o, dc_rvalid_o}, ic_rdata_o, d);
    end
    tick();                              // cycle 5
    mem_rvalid_i = 0; ic_req_i = 0;
    @(negedge clk_i);
    n_cmp++;
    if ({busy_o, ic_rvalid_o, mem_req_o} !== 3'b000) begin
      n_err++; $display("FAIL ic_c5: busy,rvalid,req %b expected 000", {busy_o, ic_rvalid_o, mem_req_o});
    end
  endtask

  task automatic test_both();
    logic [LW-1:0] d;
    d = {4{32'hBEEF_0002}};
    tick();                              // cycle 0
    ic_req_i = 1; ic_addr_i = 32'h0000_0A00;
    dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h0000_0B00;
    tick();                              // cycle 1
    @(negedge clk_i);
    n_cmp++;
    if ({ic_gnt_o, dc_gnt_o, sel_mem_req_o} !== 3'b100 || mem_addr_o !== 32'h0000_0A00) begin
      n_err++;
      $display("FAIL both_c1: igt,dgt,sel %b addr %h expected 100 / 00000a00",
               {ic_gnt_o, dc_gnt_o, sel_mem_req_o}, mem_addr_o);
    end
    tick();                              // cycle 2 = R
    mem_rvalid_i = 1; mem_rdata_i = d;
    @(negedge clk_i);
    n_cmp++;
    if ({ic_rvalid_o, dc_rvalid_o} !== 2'b10) begin
      n_err++; $display("FAIL both_ic_resp: rvalid %b expected 10", {ic_rvalid_o, dc_rvalid_o});
    end
    tick();                              // cycle 3 = R+1, IDLE
    mem_rvalid_i = 0; ic_req_i = 0;
    @(negedge clk_i);
    n_cmp++;
    if ({busy_o, mem_req_o, dc_gnt_o} !== 3'b000) begin
      n_err++; $display("FAIL both_turn: busy,req,dgt %b expected 000", {busy_o, mem_req_o, dc_gnt_o});
    end
    tick();                              // cycle 4 = R+2, DC granted and answered at once
    mem_rvalid_i = 1; mem_rdata_i = ~d;
    @(negedge clk_i);
    n_cmp++;
    if ({mem_req_o, dc_gnt_o, ic_gnt_o, sel_mem_req_o, busy_o, mem_we_o} !== 6'b110110 ||
        mem_addr_o !== 32'h0000_0B00) begin
      n_err++;
      $display("FAIL both_dc_gnt: req,dgt,igt,sel,busy,we %b addr %h expected 110110 / 00000b00",
               {mem_req_o, dc_gnt_o, ic_gnt_o, sel_mem_req_o, busy_o, mem_we_o}, mem_addr_o);
    end
    n_cmp++;
    if ({dc_rvalid_o, ic_rvalid_o} !== 2'b10 || dc_rdata_o !== ~d) begin
      n_err++; $display("FAIL both_dc_resp: rvalid %b rdata %h expected 10 / %h", {dc_rvalid_o, ic_rvalid_o}, dc_rdata_o, ~d);
    end
    tick();                              // cycle 5: single WAIT cycle done
    mem_rvalid_i = 0; dc_req_i = 0;
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL both_done: busy %b expected 0", busy_o);
    end
  endtask

  task automatic test_streak();
    logic [1:0] exp_gnt;
    logic [2:0] exp_streak;
    tick();
    ic_req_i = 1; ic_addr_i = 32'h0000_1100;
    dc_req_i = 1; dc_we_i = 0; dc_addr_i = 32'h0000_2200;
    for (int i = 0; i < 5; i++) begin
      exp_gnt    = (i < 4) ? 2'b10 : 2'b01;
      exp_streak = (i < 4) ? 3'(i + 1) : 3'd0;
      tick();                            // WAIT cycle
      mem_rvalid_i = 1;
      @(negedge clk_i);
      n_cmp++;
      if ({ic_gnt_o, dc_gnt_o} !== exp_gnt || {ic_rvalid_o, dc_rvalid_o} !== exp_gnt) begin
        n_err++;
        $display("FAIL streak_gnt%0d: gnt %b rvalid %b expected %b",
                 i, {ic_gnt_o, dc_gnt_o}, {ic_rvalid_o, dc_rvalid_o}, exp_gnt);
      end
      n_cmp++;
      if (dut.ic_streak_q !== exp_streak) begin
        n_err++; $display("FAIL streak_cnt%0d: ic_streak %0d expected %0d", i, dut.ic_streak_q, exp_streak);
      end
      tick();                            // back in IDLE
      mem_rvalid_i = 0;
      if (i == 4) begin
        ic_req_i = 0; dc_req_i = 0;
      end
    end
  endtask

  task automatic test_writeback();
    logic [LW-1:0] pat;
    pat = {16{8'hA5}};
    tick();
    dc_req_i = 1; dc_we_i = 1; dc_addr_i = 32'h0000_3300; dc_wdata_i = pat;
    for (int c = 1; c <= 3; c++) begin
      tick();
      if (c == 1) begin
        dc_wdata_i = '0; dc_we_i = 0; dc_addr_i = 32'hFFFF_FFFF;
      end
      if (c == 3) mem_rvalid_i = 1;
      @(negedge clk_i);
      n_cmp++;
      if ({mem_we_o, sel_mem_req_o, busy_o, mem_req_o} !== {3'b111, c == 1} ||
          mem_wdata_o !== pat || mem_addr_o !== 32'h0000_3300) begin
        n_err++;
        $display("FAIL wb_c%0d: we,sel,busy,req %b wdata %h addr %h expected %b / %h / 00003300",
                 c, {mem_we_o, sel_mem_req_o, busy_o, mem_req_o}, mem_wdata_o, mem_addr_o,
                 {3'b111, c == 1}, pat);
      end
      n_cmp++;
      if ({dc_rvalid_o, ic_rvalid_o} !== {c == 3, 1'b0}) begin
        n_err++; $display("FAIL wb_rvalid_c%0d: rvalid %b expected %b", c, {dc_rvalid_o, ic_rvalid_o}, {c == 3, 1'b0});
      end
    end
    tick();
    mem_rvalid_i = 0; dc_req_i = 0;
    @(negedge clk_i);
    n_cmp++;
    if (busy_o !== 1'b0) begin
      n_err++; $display("FAIL wb_done: busy %b expected 0", busy_o);
    end
  endtask

  task automatic test_reset_mid();
    tick();
    dc_req_i = 1; dc_we_i = 1; dc_addr_i = 32'h0000_4400; dc_wdata_i = {4{32'h1234_5678}};
    tick();                              // WAIT_DC first cycle
    tick();                              // WAIT_DC second cycle
    mem_rvalid_i = 1;
    #1;
    rsn_i = 0;
    #1;                                  // no clock edge since reset assertion
    n_cmp++;
    if ({ic_gnt_o, ic_rvalid_o, dc_gnt_o, dc_rvalid_o, mem_req_o, mem_we_o,
         sel_mem_req_o, busy_o} !== 8'b0 || mem_addr_o !== '0 || mem_wdata_o !== '0) begin
      n_err++;
      $display("FAIL reset_mid: ctrl %b addr %h wdata %h expected all zero",
               {ic_gnt_o, ic_rvalid_o, dc_gnt_o, dc_rvalid_o, mem_req_o, mem_we_o,
                sel_mem_req_o, busy_o}, mem_addr_o, mem_wdata_o);
    end
    mem_rvalid_i = 0; dc_req_i = 0; dc_we_i = 0;
    @(negedge clk_i);
    rsn_i = 1;
    tick();
    ic_req_i = 1; ic_addr_i = 32'h0000_5500;
    tick();
    mem_rvalid_i = 1;
    @(negedge clk_i);
    n_cmp++;
    if ({ic_gnt_o, mem_req_o, ic_rvalid_o, sel_mem_req_o} !== 4'b1110 || mem_addr_o !== 32'h0000_5500) begin
      n_err++;
      $display("FAIL post_reset: gnt,req,rvalid,sel %b addr %h expected 1110 / 00005500",
               {ic_gnt_o, mem_req_o, ic_rvalid_o, sel_mem_req_o}, mem_addr_o);
    end
    tick();
    mem_rvalid_i = 0; ic_req_i = 0;
  endtask

  task automatic test_spurious();
    tick();
    mem_rvalid_i = 1;
    @(negedge clk_i);
    n_cmp++;
    if ({ic_rvalid_o, dc_rvalid_o, busy_o} !== 3'b000) begin
      n_err++; $display("FAIL spur_idle: irv,drv,busy %b expected 000", {ic_rvalid_o, dc_rvalid_o, busy_o});
    end
    tick();
    mem_rvalid_i = 0;
    @(negedge clk_i);
    n_cmp++;
    if ({busy_o, mem_req_o, sel_mem_req_o} !== 3'b000) begin
      n_err++; $display("FAIL spur_after: busy,req,sel %b expected 000", {busy_o, mem_req_o, sel_mem_req_o});
    end
  endtask

  initial begin
    test_reset();
    test_ic_only();
    test_both();
    test_streak();
    test_writeback();
    test_reset_mid();
    test_spurious();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/segre_mem_arbiter.md
# segre_mem_arbiter

- Sequential arbiter sharing the single main-memory port between the instruction cache (IC) and the data cache (DC).
- Replaces the combinational IC/DC select in the pipeline controller. Tracks transaction ownership until the memory responds, then routes the response back to the owning cache.
- IC has priority. A bounded-streak rule prevents DC starvation.
- Sits between the two caches and main memory; drives the address/data muxes toward memory.

## Interface

Parameters:

- ADDR_SIZE, 32, request address width
- LINE_SIZE, 128, cache line width (read data and write data)
- MAX_IC_STREAK, 4, maximum consecutive IC grants while DC is waiting (≥1)

Ports:

- Clock and reset (one clock; reset is asynchronous and active-low):
  - clk_i  in  1  clock
  - rsn_i  in  1  reset, asynchronous, active-low
- IC requester:
  - ic_req_i  in  1  IC line-fill request, held until ic_rvalid_o
  - ic_addr_i  in  ADDR_SIZE  IC line address
  - ic_gnt_o  out  1  one-cycle pulse: IC request issued to memory
  - ic_rvalid_o  out  1  one-cycle pulse: IC fill data valid
  - ic_rdata_o  out  LINE_SIZE  fill data (mem_rdata_i passthrough)
- DC requester:
  - dc_req_i  in  1  DC request, held until dc_rvalid_o
  - dc_we_i  in  1  1 = write-back, 0 = fill
  - dc_addr_i  in  ADDR_SIZE  DC line address
  - dc_wdata_i  in  LINE_SIZE  write-back data
  - dc_gnt_o  out  1  one-cycle pulse: DC request issued
  - dc_rvalid_o  out  1  one-cycle pulse: DC fill data valid / write acknowledged
  - dc_rdata_o  out  LINE_SIZE  fill data (mem_rdata_i passthrough)
- Memory side:
  - mem_req_o  out  1  one-cycle request pulse
  - mem_we_o  out  1  write enable of the current transaction
  - mem_addr_o  out  ADDR_SIZE  latched address
  - mem_wdata_o  out  LINE_SIZE  latched write data
  - mem_rvalid_i  in  1  response / write acknowledge
  - mem_rdata_i  in  LINE_SIZE  response data
- Status:
  - sel_mem_req_o  out  1  0 = IC owns the port, 1 = DC owns the port
  - busy_o  out  1  transaction outstanding

## Operation

- FSM states: IDLE, WAIT_IC, WAIT_DC.
- IDLE arbitration (combinational on the requests; takes effect at the next edge):
  - Only ic_req_i: go to WAIT_IC.
  - Only dc_req_i: go to WAIT_DC.
  - Both requesting: WAIT_DC if ic_streak == MAX_IC_STREAK, otherwise WAIT_IC.
  - Neither requesting: stay in IDLE.
- On entering WAIT_x, register the following and hold them stable for the whole WAIT state:
  - mem_addr_o from the owner's address.
  - mem_we_o = dc_we_i for a DC transaction; mem_we_o = 0 for an IC transaction.
  - mem_wdata_o = dc_wdata_i for a DC transaction; mem_wdata_o = 0 for an IC transaction.
- mem_req_o and the owner's gnt pulse high only in the first cycle of WAIT_x.
- WAIT_x with mem_rvalid_i = 1:
  - Owner's rvalid_o = 1 in the same cycle (combinational).
  - Next state IDLE.
  - mem_rvalid_i is accepted in any WAIT cycle, including the mem_req_o cycle.
- ic_streak counter, width $clog2(MAX_IC_STREAK+1):
  - Increments (saturating) when IC is granted while dc_req_i = 1.
  - Clears to 0 when DC is granted, or when IDLE sees dc_req_i = 0.
- sel_mem_req_o = 1 exactly in WAIT_DC; busy_o = 1 in WAIT_IC and WAIT_DC.
- rdata outputs are passthroughs of mem_rdata_i; they are meaningful only when the matching rvalid_o = 1.
- Requester contract: drop req in the cycle after rvalid unless issuing a new request. Address and data are sampled only on the arbitration edge.
- mem_rvalid_i while in IDLE is ignored; no rvalid_o pulses.
- Reset (asynchronous, any time, including mid-transaction):
  - State goes to IDLE and ic_streak to 0.
  - Every output goes to 0: gnt_o, rvalid_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, sel_mem_req_o, busy_o.
  - An outstanding transaction is dropped; the memory model is reset with the same rsn_i.

## Timing

- Request seen in IDLE at cycle T: mem_req_o and gnt pulse at T+1.
- Memory with response latency L asserts mem_rvalid_i at T+1+L; requester rvalid_o is in the same cycle.
- Turnaround: rvalid at cycle R → IDLE at R+1 → next mem_req_o no earlier than R+2.
- Simultaneous arrival of both requests in IDLE: exactly one grant; the loser stays pending with no gnt pulse.
- A request arriving during WAIT is only evaluated after returning to IDLE.
- No combinational path from requester inputs to mem_* outputs.

## Test plan

- IC-only read, memory latency 3:
  - ic_req_i at cycle 0 → mem_req_o and ic_gnt_o at cycle 1.
  - mem_rvalid_i at cycle 4 → ic_rvalid_o at cycle 4, ic_rdata_o = mem_rdata_i.
  - busy_o = 0 at cycle 5.
- Both requests at cycle 0:
  - IC granted at cycle 1 (sel_mem_req_o = 0).
  - After IC completes at R, DC granted at R+2 (sel_mem_req_o = 1, mem_addr_o = dc_addr_i).
- Starvation, MAX_IC_STREAK = 4, back-to-back IC requests with dc_req_i held high:
  - Grants go IC, IC, IC, IC, then DC on the 5th.
  - ic_streak is 0 after the DC grant.
- DC write-back, dc_we_i = 1, dc_wdata_i = 128'hA5…A5:
  - mem_we_o = 1 and mem_wdata_o equal to the pattern, stable through WAIT_DC.
  - dc_rvalid_o pulses with mem_rvalid_i.
- Reset mid-transaction: rsn_i low during WAIT_DC → all outputs 0 immediately, without waiting for a clock edge; after release, the first request is arbitrated normally.
- Spurious responses:
  - mem_rvalid_i pulsed in IDLE → no rvalid_o, state unchanged.
  - mem_rvalid_i in the same cycle as mem_req_o → completes in a single WAIT cycle.
